// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the pattern sequencer.
//   seq_state_t : HOLD (pattern on screen) / FADE (crossfade in progress)
//   rgb_t       : one {R,G,B} pixel, 8 bits per channel
//   lfsr_next   : one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package pattern_seq_pkg;

    localparam int unsigned RGB_W = 24;
    localparam int unsigned CH_W  = 8;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Bits 7,5,4,3 correspond to taps 8,6,5,4.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic {
        HOLD = 1'b0,
        FADE = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/color_blend.sv
// Crossfade of one pixel lane: out = (c*(256-alpha) + n*alpha) >> 8 per channel.
//   cur_rgb : outgoing pattern colour
//   nxt_rgb : incoming pattern colour
//   alpha   : weight of nxt_rgb, 0 gives cur_rgb exactly
//   blend_c : combinational blended colour
module color_blend
    import pattern_seq_pkg::*;
(
    input  rgb_t            cur_rgb,
    input  rgb_t            nxt_rgb,
    input  logic [CH_W-1:0] alpha,
    output rgb_t            blend_c
);

    logic [8:0] w_nxt;
    logic [8:0] w_cur;

    assign w_nxt = {1'b0, alpha};
    assign w_cur = 9'd256 - w_nxt;

    // 8x9 products summed in 17 bits; weights total 256 so the sum never exceeds 255*256.
    function automatic logic [CH_W-1:0] mix(input logic [CH_W-1:0] c, input logic [CH_W-1:0] n,
                                            input logic [8:0] wc, input logic [8:0] wn);
        logic [16:0] sum;
        sum = (17'(c) * 17'(wc)) + (17'(n) * 17'(wn));
        return 8'(sum >> 8);
    endfunction

    assign blend_c.r = mix(cur_rgb.r, nxt_rgb.r, w_cur, w_nxt);
    assign blend_c.g = mix(cur_rgb.g, nxt_rgb.g, w_cur, w_nxt);
    assign blend_c.b = mix(cur_rgb.b, nxt_rgb.b, w_cur, w_nxt);

endmodule

// File: rtl/pattern_sequencer.sv
// Chooses which colour generator drives the panel and crossfades between them.
// Optional macro PATTERN_SEQ_RANDOM_EN: pick the next pattern from an 8-bit LFSR
// instead of sequential increment.
//   clk_27MHz, rst_n : clock, async active-low reset
//   frame_tick       : one pulse per completed frame
//   next_req         : one pulse requesting the next pattern
//   auto_en          : enables timed auto-advance every HOLD_FRAMES frames
//   rgb_in           : lane L, pattern P at [(L*NUM_PAT+P)*24 +: 24]
//   rgb_out          : blended colour per lane (combinational from rgb_in)
//   cur_sel, nxt_sel : shown pattern and fade target
//   alpha            : weight of nxt_sel
//   fading, changed  : in FADE / one-cycle pulse at fade completion
module pattern_sequencer
    import pattern_seq_pkg::*;
#(
    parameter  int unsigned NUM_PAT     = 4,
    parameter  int unsigned LANES       = 2,
    parameter  int unsigned HOLD_FRAMES = 600,
    parameter  int unsigned FADE_STEP   = 8,
    localparam int unsigned SEL_W       = $clog2(NUM_PAT)
) (
    input  logic                               clk_27MHz,
    input  logic                               rst_n,
    input  logic                               frame_tick,
    input  logic                               next_req,
    input  logic                               auto_en,
    input  logic [LANES*NUM_PAT*RGB_W-1:0]     rgb_in,
    output logic [LANES*RGB_W-1:0]             rgb_out,
    output logic [SEL_W-1:0]                   cur_sel,
    output logic [SEL_W-1:0]                   nxt_sel,
    output logic [CH_W-1:0]                    alpha,
    output logic                               fading,
    output logic                               changed
);

    localparam int unsigned HOLD_W = 16;

    seq_state_t        state_q, state_d;
    logic [SEL_W-1:0]  cur_q, cur_d;
    logic [SEL_W-1:0]  nxt_q, nxt_d;
    logic [CH_W-1:0]   alpha_q, alpha_d;
    logic              fading_q, fading_d;
    logic              changed_q, changed_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pending_q, pending_d;
    logic              start_fade;
    logic [SEL_W-1:0]  pick_c;

    function automatic logic [SEL_W-1:0] inc_sel(input logic [SEL_W-1:0] s);
        return (s == SEL_W'(NUM_PAT - 1)) ? '0 : s + SEL_W'(1);
    endfunction

`ifdef PATTERN_SEQ_RANDOM_EN
    logic [7:0]       lfsr_q;
    logic [SEL_W-1:0] rnd_sel;

    // Free-running LFSR; the modulo result is always below NUM_PAT.
    always_ff @(posedge clk_27MHz or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_next(lfsr_q);
    end

    assign rnd_sel = SEL_W'(lfsr_q % 8'(NUM_PAT));
    // Never target the pattern already on screen.
    assign pick_c  = (rnd_sel == cur_q) ? inc_sel(cur_q) : rnd_sel;
`else
    assign pick_c  = inc_sel(cur_q);
`endif

    // State and control registers.
    always_ff @(posedge clk_27MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HOLD;
            cur_q      <= '0;
            nxt_q      <= SEL_W'(1 % NUM_PAT);
            alpha_q    <= '0;
            fading_q   <= 1'b0;
            changed_q  <= 1'b0;
            hold_cnt_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            alpha_q    <= alpha_d;
            fading_q   <= fading_d;
            changed_q  <= changed_d;
            hold_cnt_q <= hold_cnt_d;
            pending_q  <= pending_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        alpha_d    = alpha_q;
        fading_d   = fading_q;
        changed_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        pending_d  = pending_q;
        start_fade = 1'b0;

        case (state_q)
            HOLD: begin
                // A queued request is served here, giving the one-cycle HOLD gap after completion.
                if (next_req || pending_q) begin
                    start_fade = 1'b1;
                end else if (frame_tick && auto_en) begin
                    if (hold_cnt_q == HOLD_W'(HOLD_FRAMES - 1)) start_fade = 1'b1;
                    else                                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
                if (start_fade) begin
                    nxt_d      = pick_c;
                    alpha_d    = '0;
                    fading_d   = 1'b1;
                    hold_cnt_d = '0;
                    pending_d  = 1'b0;
                    state_d    = FADE;
                end
            end
            FADE: begin
                if (next_req) pending_d = 1'b1;
                if (frame_tick) begin
                    if (alpha_q >= CH_W'(256 - FADE_STEP)) begin
                        cur_d     = nxt_q;
                        alpha_d   = '0;
                        fading_d  = 1'b0;
                        changed_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        alpha_d = alpha_q + CH_W'(FADE_STEP);
                    end
                end
            end
            default: state_d = HOLD;
        endcase
    end

    assign cur_sel = cur_q;
    assign nxt_sel = nxt_q;
    assign alpha   = alpha_q;
    assign fading  = fading_q;
    assign changed = changed_q;

    // Per-lane pattern select and blend.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        rgb_t pats [NUM_PAT];
        rgb_t blend;

        for (genvar p = 0; p < NUM_PAT; p++) begin : g_pat
            assign pats[p] = rgb_in[(l*NUM_PAT + p)*RGB_W +: RGB_W];
        end

        color_blend u_blend (
            .cur_rgb (pats[cur_q]),
            .nxt_rgb (pats[nxt_q]),
            .alpha   (alpha_q),
            .blend_c (blend)
        );

        assign rgb_out[l*RGB_W +: RGB_W] = blend;
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with HOLD_FRAMES=4, FADE_STEP=64, NUM_PAT=4, LANES=2.
module tb_pattern_sequencer;

    localparam int unsigned NUM_PAT = 4;
    localparam int unsigned LANES   = 2;

    logic        clk_27MHz;
    logic        rst_n;
    logic        frame_tick;
    logic        next_req;
    logic        auto_en;
    logic [LANES*NUM_PAT*24-1:0] rgb_in;
    logic [LANES*24-1:0]         rgb_out;
    logic [1:0]  cur_sel;
    logic [1:0]  nxt_sel;
    logic [7:0]  alpha;
    logic        fading;
    logic        changed;

    int tests;
    int fails;

    pattern_sequencer #(
        .NUM_PAT     (NUM_PAT),
        .LANES       (LANES),
        .HOLD_FRAMES (4),
        .FADE_STEP   (64)
    ) dut (
        .clk_27MHz  (clk_27MHz),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .next_req   (next_req),
        .auto_en    (auto_en),
        .rgb_in     (rgb_in),
        .rgb_out    (rgb_out),
        .cur_sel    (cur_sel),
        .nxt_sel    (nxt_sel),
        .alpha      (alpha),
        .fading     (fading),
        .changed    (changed)
    );

    initial clk_27MHz = 1'b0;
    always #5 clk_27MHz = ~clk_27MHz;

    // Lane1 then lane0, each {p3,p2,p1,p0}.
    localparam logic [191:0] RGB_IN = {24'h445566, 24'h112233, 24'hA0C0E0, 24'h204060,
                                       24'h123456, 24'h00FF00, 24'h0000FF, 24'hFF0000};
    // Expected {lane1, lane0} for cur=0/nxt=1 at alpha 0,64,128,192 and for cur=1 at alpha 0.
    localparam logic [47:0] B_A0   = {24'h204060, 24'hFF0000};
    localparam logic [47:0] B_A64  = {24'h406080, 24'hBF003F};
    localparam logic [47:0] B_A128 = {24'h6080A0, 24'h7F007F};
    localparam logic [47:0] B_A192 = {24'h80A0C0, 24'h3F00BF};
    localparam logic [47:0] B_CUR1 = {24'hA0C0E0, 24'h0000FF};

    typedef struct {
        logic        ft, nr, ae;
        logic [1:0]  cur, nxt;
        logic [7:0]  alpha;
        logic        fading, changed, chk_rgb;
        logic [47:0] rgb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ft, input logic nr, input logic ae,
                       input int cur, input int nxt, input int a,
                       input logic f, input logic c, input logic chk, input logic [47:0] rgb);
        vec_t v;
        v.ft = ft; v.nr = nr; v.ae = ae;
        v.cur = 2'(cur); v.nxt = 2'(nxt); v.alpha = 8'(a);
        v.fading = f; v.changed = c; v.chk_rgb = chk; v.rgb = rgb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input int cur, input int nxt, input int a,
                               input logic f, input logic c);
        check({name, " cur_sel"}, 64'(cur_sel), 64'(cur));
        check({name, " nxt_sel"}, 64'(nxt_sel), 64'(nxt));
        check({name, " alpha"},   64'(alpha),   64'(a));
        check({name, " fading"},  64'(fading),  64'(f));
        check({name, " changed"}, 64'(changed), 64'(c));
    endtask

    // One clock: inputs set on the falling edge, outputs settle 1 time unit after the rising edge.
    task automatic step(input logic ft, input logic nr, input logic ae);
        @(negedge clk_27MHz);
        frame_tick = ft;
        next_req   = nr;
        auto_en    = ae;
        @(posedge clk_27MHz);
        #1;
        frame_tick = 1'b0;
        next_req   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_27MHz);
        rst_n = 1'b0;
        @(negedge clk_27MHz);
        rst_n = 1'b1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        next_req   = 1'b0;
        auto_en    = 1'b0;
        rgb_in     = RGB_IN;

        repeat (3) @(posedge clk_27MHz);
        #1;
        check_state("reset", 0, 1, 0, 1'b0, 1'b0);
        check("reset rgb_out", 64'(rgb_out), 64'(B_A0));
        @(negedge clk_27MHz);
        rst_n = 1'b1;

`ifdef PATTERN_SEQ_RANDOM_EN
        // Random pick: target never equals the shown pattern, and completion adopts it.
        for (int i = 0; i < 100; i++) begin
            logic [1:0] tgt;
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("rnd%0d fading", i), 64'(fading), 64'(1));
            tests++;
            if (nxt_sel === cur_sel) begin
                fails++;
                $display("FAIL rnd%0d target: nxt_sel %0d equals cur_sel %0d", i, nxt_sel, cur_sel);
            end
            tgt = nxt_sel;
            repeat (4) step(1'b1, 1'b0, 1'b0);
            check($sformatf("rnd%0d cur_sel", i), 64'(cur_sel), 64'(tgt));
            check($sformatf("rnd%0d changed", i), 64'(changed), 64'(1));
        end
`else
        // Auto-advance, full fade, queued requests, wrap, and request on the completion cycle.
        add(1,0,1, 0,1,0,   0,0, 1, B_A0);
        add(1,0,1, 0,1,0,   0,0, 1, B_A0);
        add(1,0,1, 0,1,0,   0,0, 1, B_A0);
        add(1,0,1, 0,1,0,   1,0, 1, B_A0);
        add(0,0,1, 0,1,0,   1,0, 1, B_A0);
        add(1,0,1, 0,1,64,  1,0, 1, B_A64);
        add(1,0,1, 0,1,128, 1,0, 1, B_A128);
        add(1,0,1, 0,1,192, 1,0, 1, B_A192);
        add(1,0,1, 1,1,0,   0,1, 1, B_CUR1);
        add(0,0,1, 1,1,0,   0,0, 1, B_CUR1);
        add(0,1,0, 1,2,0,   1,0, 1, B_CUR1);
        add(0,1,0, 1,2,0,   1,0, 0, '0);
        add(0,1,0, 1,2,0,   1,0, 0, '0);
        add(1,0,0, 1,2,64,  1,0, 0, '0);
        add(1,0,0, 1,2,128, 1,0, 0, '0);
        add(1,0,0, 1,2,192, 1,0, 0, '0);
        add(1,0,0, 2,2,0,   0,1, 0, '0);
        add(0,0,0, 2,3,0,   1,0, 0, '0);
        add(0,0,0, 2,3,0,   1,0, 0, '0);
        add(1,0,0, 2,3,64,  1,0, 0, '0);
        add(1,0,0, 2,3,128, 1,0, 0, '0);
        add(1,0,0, 2,3,192, 1,0, 0, '0);
        add(1,0,0, 3,3,0,   0,1, 0, '0);
        add(0,0,0, 3,3,0,   0,0, 0, '0);
        add(0,0,0, 3,3,0,   0,0, 0, '0);
        add(0,1,0, 3,0,0,   1,0, 0, '0);
        add(1,0,0, 3,0,64,  1,0, 0, '0);
        add(1,0,0, 3,0,128, 1,0, 0, '0);
        add(1,0,0, 3,0,192, 1,0, 0, '0);
        add(1,1,0, 0,0,0,   0,1, 1, B_A0);
        add(0,0,0, 0,1,0,   1,0, 1, B_A0);
        add(1,0,0, 0,1,64,  1,0, 1, B_A64);
        add(1,0,0, 0,1,128, 1,0, 1, B_A128);
        add(1,0,0, 0,1,192, 1,0, 1, B_A192);
        add(1,0,0, 1,1,0,   0,1, 1, B_CUR1);
        add(0,0,0, 1,1,0,   0,0, 1, B_CUR1);

        foreach (vecs[i]) begin
            step(vecs[i].ft, vecs[i].nr, vecs[i].ae);
            check_state($sformatf("row%0d", i), int'(vecs[i].cur), int'(vecs[i].nxt),
                        int'(vecs[i].alpha), vecs[i].fading, vecs[i].changed);
            if (vecs[i].chk_rgb)
                check($sformatf("row%0d rgb_out", i), 64'(rgb_out), 64'(vecs[i].rgb));
        end

        // auto_en=0 freezes hold_cnt without clearing it.
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("freeze 3rd counted tick", 64'(fading), 64'(0));
        step(1'b1, 1'b0, 1'b1);
        check_state("freeze 4th counted tick", 1, 2, 0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        check_state("freeze fade done", 2, 2, 0, 1'b0, 1'b1);

        // No auto-advance with auto_en low.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("auto off tick%0d fading", i), 64'(fading), 64'(0));
        end

        // frame_tick with next_req: one fade, tick not counted, hold_cnt restarts.
        repeat (2) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_state("tick+req start", 2, 3, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_state("tick+req idle", 2, 3, 0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        check_state("tick+req done", 3, 3, 0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        check("hold restart 3 ticks", 64'(fading), 64'(0));
        step(1'b1, 1'b0, 1'b1);
        check_state("hold restart 4th tick", 3, 0, 0, 1'b1, 1'b0);
`endif

        // Asynchronous reset in the middle of a fade.
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        check("pre-reset alpha", 64'(alpha), 64'(128));
        check("pre-reset fading", 64'(fading), 64'(1));
        @(posedge clk_27MHz);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async reset", 0, 1, 0, 1'b0, 1'b0);
        check("async reset rgb_out", 64'(rgb_out), 64'(B_A0));
        @(negedge clk_27MHz);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check_state("after reset", 0, 1, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
